// File: rtl/alu_issue_ctrl.sv
// Issue controller sequencing one decoded instruction through the 16-bit ALU (setup, EN pulse, capture, handshake out).
// Optional macro ALU_ISSUE_ILLEGAL_TRAP_EN: trap illegal opcodes (9-15) instead of running them through the ALU.
module alu_issue_ctrl #(
    parameter int WIDTH = 16,
    parameter int RD_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_rs1_data,
    input  logic [WIDTH-1:0] in_rs2_data,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [RD_W-1:0]  in_rd,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_en,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_opcode,
    output logic [RD_W-1:0]  out_rd,
    output logic [WIDTH-1:0] out_store_data,
    output logic             illegal_op
);
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_FIRE, S_CAPTURE, S_HOLD} state_t;

    state_t           r_state, w_next;
    logic [3:0]       r_op, r_out_op;
    logic [WIDTH-1:0] r_a, r_b, r_sd, r_out_result, r_out_sd;
    logic [RD_W-1:0]  r_rd, r_out_rd;
    logic             w_accept, w_trap;

    assign w_accept = in_valid && (r_state == S_IDLE);

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic r_illegal;
    // Set on acceptance so the pulse lands in the SETUP cycle.
    always_ff @(posedge clk) begin
        if (reset) r_illegal <= 1'b0;
        else       r_illegal <= w_accept && (in_opcode > OP_SW);
    end
    assign w_trap = r_illegal;
`else
    assign w_trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_SETUP;
            S_SETUP:   w_next = w_trap ? S_IDLE : S_FIRE;
            S_FIRE:    w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_HOLD;
            S_HOLD:    if (out_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_sd         <= '0;
            r_rd         <= '0;
            r_out_op     <= '0;
            r_out_result <= '0;
            r_out_sd     <= '0;
            r_out_rd     <= '0;
        end else begin
            if (w_accept) begin
                r_op <= in_opcode;
                r_a  <= in_rs1_data;
                r_b  <= (in_opcode <= OP_SUB) ? in_rs2_data : in_imm;
                r_sd <= (in_opcode == OP_SW) ? in_rs2_data : '0;
                r_rd <= in_rd;
            end
            // Output side loads in one shot so everything out_* changes together.
            if (r_state == S_CAPTURE) begin
                r_out_result <= alu_result;
                r_out_op     <= r_op;
                r_out_rd     <= r_rd;
                r_out_sd     <= r_sd;
            end
        end
    end

    // Gating by reset kills the EN pulse in the same cycle reset is raised.
    assign alu_en         = (r_state == S_FIRE) && !reset;
    assign in_ready       = (r_state == S_IDLE) && !reset;
    assign out_valid      = (r_state == S_HOLD);
    assign alu_op         = r_op;
    assign alu_a          = r_a;
    assign alu_b          = r_b;
    assign out_result     = r_out_result;
    assign out_opcode     = r_out_op;
    assign out_rd         = r_out_rd;
    assign out_store_data = r_out_sd;
    assign illegal_op     = w_trap;
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue controller that drives the 16-bit ALU from the decode stage. It accepts one decoded instruction per handshake and selects the ALU operands and opcode. It sequences the ALU enable pulse, registers the ALU result, and presents it to the memory/writeback stage over a valid/ready handshake. It is the initiator side of the ALU's `ALUop`/`EN`/operand/`Output` interface.

## Interface
Parameters:
- `WIDTH`, 16, datapath width; only 16 is supported.
- `RD_W`, 3, destination register index width.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: decode stage has an instruction.
- `in_ready` out 1: controller can accept an instruction.
- `in_opcode` in 4: instruction opcode.
- `in_rs1_data` in WIDTH: register operand 1.
- `in_rs2_data` in WIDTH: register operand 2; also the store data for SW.
- `in_imm` in WIDTH: immediate, already extended by decode.
- `in_rd` in RD_W: destination register index.
- `alu_op` out 4: drives ALU `ALUop`.
- `alu_a` out WIDTH: drives ALU `A`.
- `alu_b` out WIDTH: drives ALU `B`.
- `alu_en` out 1: drives ALU `EN`.
- `alu_result` in WIDTH: the ALU `Output`.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts the result.
- `out_result` out WIDTH: captured ALU result (a memory address for LW/LBu/LBs/SW).
- `out_opcode` out 4: opcode of the result.
- `out_rd` out RD_W: destination register index.
- `out_store_data` out WIDTH: rs2 value for SW, otherwise 0.
- `illegal_op` out 1: one-cycle pulse on an illegal opcode (see Configuration).

## Operation
Opcode encoding (shared constants): AND=0, ADD=1, SUB=2, ADDI=3, ANDI=4, LW=5, LBu=6, LBs=7, SW=8. Values 9–15 are illegal.

Operand selection:
- `alu_a` = rs1.
- `alu_b` = rs2 for AND, ADD and SUB.
- `alu_b` = imm for ADDI, ANDI, LW, LBu, LBs and SW.
- `alu_op` = `in_opcode`, passed through unchanged.

The ALU re-evaluates on every transition of `EN`, so `alu_op`, `alu_a` and `alu_b` are registered. They hold stable from SETUP through CAPTURE inclusive.

FSM states:
- IDLE: `in_ready`=1. On `in_valid`, latch the opcode, operands, rd and store data, then go to SETUP.
- SETUP: drive the operand registers; `alu_en`=0. Go to FIRE.
- FIRE: `alu_en`=1 for exactly this cycle. Go to CAPTURE.
- CAPTURE: `alu_en`=0. Register `alu_result` into `out_result`. Go to HOLD.
- HOLD: `out_valid`=1 and all `out_*` stable. On `out_ready`, go to IDLE.

Rules:
- `in_ready` is high only in IDLE.
- `in_valid` arriving outside IDLE is ignored; decode must hold it until accepted.
- Arithmetic is modulo 2^16: ADD and SUB wrap, and the carry/borrow is discarded.
- Reset:
  - All outputs go to 0 and the state to IDLE.
  - A reset in any state aborts the instruction. No result is emitted and `alu_en` is forced to 0 in the same cycle.
  - `in_ready`=1 from the first cycle after reset deasserts.

## Timing
- Accept at cycle 0 (edge where `in_valid`&`in_ready`).
- SETUP is cycle 1, FIRE (`alu_en`=1) is cycle 2, CAPTURE is cycle 3.
- `out_valid`=1 from cycle 4.
- With `out_ready` held high, the next accept occurs at cycle 5, so peak throughput is 1 instruction per 5 cycles.
- Backpressure: HOLD persists indefinitely with every output frozen. `alu_en` stays 0.
- `illegal_op`, when enabled, pulses in cycle 1.

## Configuration
Macro: `ALU_ISSUE_ILLEGAL_TRAP_EN`.
- Defined:
  - An illegal opcode pulses `illegal_op` in cycle 1 and returns to IDLE.
  - There is no `alu_en` pulse and no `out_valid`.
  - `in_ready`=1 again in cycle 2.
- Undefined:
  - `illegal_op` is tied to 0.
  - An illegal opcode runs the full sequence, and the ALU default gives `out_result`=0.
  - `out_opcode` carries the illegal value.

## Test plan
- ADD with rs1=0x7FFF, rs2=0x0001, rd=3 and `out_ready`=1: `alu_en` high only in cycle 2; `out_valid` in cycle 4 with `out_result`=0x8000, `out_rd`=3; `in_ready` high again in cycle 5.
- SUB with rs1=0x0000, rs2=0x0001: `out_result`=0xFFFF (wrap). ANDI with rs1=0xF0F0, imm=0x00FF, rs2=0x1234: `alu_b`=0x00FF and `out_result`=0x00F0.
- SW with rs1=0x0100, imm=0x0004, rs2=0xBEEF: `out_result`=0x0104, `out_store_data`=0xBEEF, `out_opcode`=8.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`. Outputs stay frozen and `in_ready`=0; a second `in_valid` is not accepted. Release `out_ready`: IDLE follows next cycle and the second instruction is accepted.
- Assert `reset` during FIRE: `alu_en`=0 and all outputs are 0 on the next edge; `out_valid` never rises; `in_ready`=1 in the cycle after reset deasserts.
- Opcode 12:
  - With `ALU_ISSUE_ILLEGAL_TRAP_EN` defined: `illegal_op` pulses in cycle 1, no `alu_en`, no `out_valid`.
  - With it undefined: `out_valid` in cycle 4 with `out_result`=0.
